stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter PRESCALE, default 10: clk cycles per least-significant-digit tick, legal range 2..65535.
REQ-002 Parameter NDIG, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 start_stop  input  1  one-cycle command pulse to toggle between counting and paused.
REQ-006 lap  input  1  one-cycle command pulse to freeze or unfreeze the display while counting continues.
REQ-007 clear  input  1  one-cycle command pulse to zero the stopwatch; effective only in IDLE or PAUSE.
REQ-008 time_bcd  output  4*NDIG  displayed time, digit 0 in bits [3:0]; each nibble 0..9.
REQ-009 running  output  1  high in RUN and LAP_HOLD.
REQ-010 lapped  output  1  high in LAP_HOLD.
REQ-011 overflow  output  1  sticky flag set on full-scale wrap.

Function
REQ-012 FSM states SHALL be IDLE, RUN, PAUSE and LAP_HOLD; all outputs are registered.
REQ-013 IDLE: start_stop -> RUN; lap and clear ignored.
REQ-014 RUN: start_stop -> PAUSE; lap -> LAP_HOLD and the display register captures the current count in the same edge.
REQ-015 LAP_HOLD: lap -> RUN with live display; start_stop -> PAUSE with live display.
REQ-016 PAUSE: start_stop -> RUN; clear -> IDLE.
REQ-017 Simultaneous pulses SHALL resolve by priority clear > start_stop > lap; a lower-priority pulse in the same cycle is discarded, and clear in RUN/LAP_HOLD is discarded.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 in RUN and LAP_HOLD, hold its value in PAUSE, and be 0 in IDLE; tick is asserted combinationally when prescaler == PRESCALE-1 in a counting state.
REQ-019 Digit 0 SHALL increment on tick; digit k SHALL increment on tick when digits 0..k-1 all equal 9; a digit at 9 that increments wraps to 0.
REQ-020 When all digits equal 9 and tick occurs, all digits SHALL become 0 and overflow SHALL be set; counting continues.
REQ-021 overflow SHALL stay set until clear takes effect or reset.
REQ-022 time_bcd SHALL show the live count in IDLE, RUN and PAUSE, and the captured value in LAP_HOLD.
REQ-023 Latency: with a start_stop pulse in cycle 0 from IDLE, time_bcd SHALL first read 1 in cycle PRESCALE+1.
REQ-024 Clear taking effect SHALL zero digits, prescaler, display capture and overflow in the same edge.

Reset
REQ-025 reset_n low at a clk edge SHALL force IDLE, time_bcd = 0, prescaler = 0, running = 0, lapped = 0 and overflow = 0, regardless of state or concurrent pulses.
REQ-026 Reset asserted mid-count or in LAP_HOLD SHALL discard the captured lap value; no command is honoured in the reset cycle.

Structure
REQ-027 Shared package stopwatch_pkg SHALL hold the state encoding (2-bit, four states) and the constant BCD_MAX = 9.
REQ-028 The digit chain SHALL use NDIG instances of sub-module bcd_digit: clk, reset_n, clr, inc, 4-bit value and carry-out (value == 9 & inc).
REQ-029 Prescaler, FSM, display capture and overflow flag SHALL reside in stopwatch_ctrl.

Verification (PRESCALE=4, NDIG=4)
REQ-030 Reset, start_stop at cycle 0 -> running=1 from cycle 1; time_bcd = 0x0001 in cycle 5 and 0x0002 in cycle 9.
REQ-031 Run 40 ticks, then lap -> lapped=1 and time_bcd frozen at 0x0040; 8 cycles later lap again -> time_bcd = 0x0042 the next cycle.
REQ-032 Run to 0x0007 plus 2 prescaler cycles, start_stop -> PAUSE, hold 20 cycles with time_bcd = 0x0007; start_stop -> next increment arrives 2 cycles after RUN is entered.
REQ-033 Preload by running to 0x9999, next tick -> time_bcd = 0x0000 and overflow = 1; overflow stays 1 through a pause, then clear -> overflow = 0 and IDLE.
REQ-034 In PAUSE at 0x0123, assert clear, start_stop and lap together -> IDLE, time_bcd = 0x0000; the same triple in RUN -> PAUSE, count held.
REQ-035 reset_n low for one edge while in LAP_HOLD at 0x0015 -> next cycle IDLE, all outputs 0; subsequent lap pulse ignored.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller and its BCD digit chain.
// Holds the 2-bit FSM encoding, the top BCD digit value and a state decode helper.
// Pure declarations; no logic or timing of its own.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_PAUSE    = 2'd2,
      ST_LAP_HOLD = 2'd3
   } sw_state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // The prescaler and digit chain advance only in these two states.
   function automatic logic is_counting(input sw_state_e s);
      return (s == ST_RUN) || (s == ST_LAP_HOLD);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch count, 0..9 with wrap.
// Value updates on the clock edge after inc; carry is combinational from value and inc.
// clr wins over inc; reset_n is synchronous and active low.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] value,
   output logic       carry
);

   logic [3:0] value_q;
   logic [3:0] value_d;

   // Next digit value: clear, wrap at 9, or plain increment.
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = 4'd0;
      end else if (inc) begin
         value_d = (value_q == BCD_MAX) ? 4'd0 : value_q + 4'd1;
      end
   end

   // Digit register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         value_q <= 4'd0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign carry = (value_q == BCD_MAX) && inc;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch: start/pause, lap freeze and clear over an NDIG-digit BCD count.
// Digit 0 advances every PRESCALE cycles while counting; first increment is visible PRESCALE+1 cycles after start.
// Commands are single-cycle pulses, resolved by priority clear > start_stop > lap; no backpressure.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int PRESCALE = 10,
   parameter int NDIG     = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_stop,
   input  logic              lap,
   input  logic              clear,
   output logic [4*NDIG-1:0] time_bcd,
   output logic              running,
   output logic              lapped,
   output logic              overflow
);

   localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   sw_state_e          state_q, state_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [4*NDIG-1:0]  cap_q, cap_d;
   logic               ovf_q, ovf_d;
   logic               running_q, lapped_q;

   logic               clr_eff;
   logic               cap_load;
   logic               tick;
   logic [NDIG-1:0]    inc;
   logic [NDIG-1:0]    carry;
   logic [4*NDIG-1:0]  digits;

   // Next state from the command pulses; lower-priority pulses in the same cycle are dropped.
   always_comb begin
      state_d  = state_q;
      clr_eff  = 1'b0;
      cap_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               clr_eff = 1'b1;
            end else if (start_stop) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (start_stop) begin
               state_d = ST_PAUSE;
            end else if (lap) begin
               state_d  = ST_LAP_HOLD;
               cap_load = 1'b1;
            end
         end
         ST_LAP_HOLD: begin
            if (start_stop) begin
               state_d = ST_PAUSE;
            end else if (lap) begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (clear) begin
               state_d = ST_IDLE;
               clr_eff = 1'b1;
            end else if (start_stop) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign tick = is_counting(state_q) && (presc_q == PRESC_LAST);

   // Prescaler, lap capture and sticky overflow next values.
   always_comb begin
      presc_d = presc_q;
      cap_d   = cap_q;
      ovf_d   = ovf_q | carry[NDIG-1];
      if (clr_eff || state_q == ST_IDLE) begin
         presc_d = '0;
      end else if (is_counting(state_q)) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
      if (clr_eff) begin
         cap_d = '0;
         ovf_d = 1'b0;
      end else if (cap_load) begin
         cap_d = digits;
      end
   end

   // Control registers; reset also drops any captured lap value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         cap_q     <= '0;
         ovf_q     <= 1'b0;
         running_q <= 1'b0;
         lapped_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         cap_q     <= cap_d;
         ovf_q     <= ovf_d;
         running_q <= is_counting(state_d);
         lapped_q  <= (state_d == ST_LAP_HOLD);
      end
   end

   // Ripple-enable chain: digit k advances when tick and all lower digits are at 9.
   assign inc = NDIG'({carry, tick});

   for (genvar g = 0; g < NDIG; g++) begin : g_digit
      bcd_digit u_digit (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (clr_eff),
         .inc     (inc[g]),
         .value   (digits[4*g +: 4]),
         .carry   (carry[g])
      );
   end

   // Display selects between two registers under a registered flag, so it never glitches.
   assign time_bcd = lapped_q ? cap_q : digits;
   assign running  = running_q;
   assign lapped   = lapped_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed checks of stopwatch_ctrl with PRESCALE=4, NDIG=4.
// Stimulus pushes the expected outputs for the current cycle; a monitor compares at the falling edge.
// Cycle n is the interval after the n-th rising edge; a pulse driven in cycle n acts on the edge ending it.
module tb_stopwatch_ctrl;

    localparam int P = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start_stop = 1'b0;
    logic           lap = 1'b0;
    logic           clear = 1'b0;
    logic [4*N-1:0] time_bcd;
    logic           running;
    logic           lapped;
    logic           overflow;

    stopwatch_ctrl #(.PRESCALE(P), .NDIG(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .time_bcd   (time_bcd),
        .running    (running),
        .lapped     (lapped),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] t;
        logic        r;
        logic        l;
        logic        o;
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    // Monitor: pop every expectation due this cycle and compare mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.cyc != cyc ||
                {time_bcd, running, lapped, overflow} !== {e.t, e.r, e.l, e.o}) begin
                bad++;
                $display("FAIL %s cyc=%0d: got time=%h run=%b lap=%b ovf=%b, want time=%h run=%b lap=%b ovf=%b",
                         e.tag, cyc, time_bcd, running, lapped, overflow, e.t, e.r, e.l, e.o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic expect_now(input string tag, input logic [15:0] t,
                              input logic r, input logic l, input logic o);
        exp_t x;
        x.cyc = cyc; x.t = t; x.r = r; x.l = l; x.o = o; x.tag = tag;
        q.push_back(x);
    endtask

    task automatic check_now(input string tag, input logic [15:0] t,
                             input logic r, input logic l, input logic o);
        total++;
        if ({time_bcd, running, lapped, overflow} !== {t, r, l, o}) begin
            bad++;
            $display("FAIL %s cyc=%0d: got time=%h run=%b lap=%b ovf=%b, want time=%h run=%b lap=%b ovf=%b",
                     tag, cyc, time_bcd, running, lapped, overflow, t, r, l, o);
        end
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic cl);
        start_stop = ss; lap = lp; clear = cl;
        step();
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        expect_now("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    int s;
    int t;

    initial begin
        // Power-up reset held for two edges.
        step();
        step();
        reset_n = 1'b1;
        check_now("reset0_direct", 16'h0000, 1'b0, 1'b0, 1'b0);
        expect_now("reset0", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Start latency: count k is visible from cycle s+1+4k.
        s = cyc;
        pulse(1'b1, 1'b0, 1'b0);
        expect_now("run_c1", 16'h0000, 1'b1, 1'b0, 1'b0);
        wait_to(s + 4);   expect_now("pre_tick", 16'h0000, 1'b1, 1'b0, 1'b0);
        wait_to(s + 5);   expect_now("first_tick", 16'h0001, 1'b1, 1'b0, 1'b0);
        wait_to(s + 9);   expect_now("second_tick", 16'h0002, 1'b1, 1'b0, 1'b0);

        // Lap at 40: display frozen while the live count reaches 42.
        wait_to(s + 161); expect_now("at40", 16'h0040, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        expect_now("lap_in", 16'h0040, 1'b1, 1'b1, 1'b0);
        wait_to(s + 166); expect_now("lap_frozen", 16'h0040, 1'b1, 1'b1, 1'b0);
        wait_to(s + 169);
        pulse(1'b0, 1'b1, 1'b0);
        expect_now("lap_out", 16'h0042, 1'b1, 1'b0, 1'b0);

        // Lap at 43, then start_stop from LAP_HOLD pauses with the live value 44.
        wait_to(s + 173);
        pulse(1'b0, 1'b1, 1'b0);
        expect_now("lap2_in", 16'h0043, 1'b1, 1'b1, 1'b0);
        wait_to(s + 177); expect_now("lap2_frozen", 16'h0043, 1'b1, 1'b1, 1'b0);
        wait_to(s + 178);
        pulse(1'b1, 1'b0, 1'b0);
        expect_now("hold_to_pause", 16'h0044, 1'b0, 1'b0, 1'b0);
        wait_to(s + 185); expect_now("pause_44", 16'h0044, 1'b0, 1'b0, 1'b0);

        // Pause at 7 with prescaler held at 2; resume gives 8 two cycles after RUN is entered.
        do_reset();
        s = cyc;
        pulse(1'b1, 1'b0, 1'b0);
        wait_to(s + 29);  expect_now("at7", 16'h0007, 1'b1, 1'b0, 1'b0);
        wait_to(s + 30);
        pulse(1'b1, 1'b0, 1'b0);
        expect_now("paused7", 16'h0007, 1'b0, 1'b0, 1'b0);
        wait_to(s + 50);  expect_now("paused7_late", 16'h0007, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        expect_now("resume", 16'h0007, 1'b1, 1'b0, 1'b0);
        step();           expect_now("resume_p3", 16'h0007, 1'b1, 1'b0, 1'b0);
        step();           expect_now("resume_8", 16'h0008, 1'b1, 1'b0, 1'b0);

        // Full-scale run: carry into upper digits, wrap to 0 with sticky overflow, then clear.
        do_reset();
        s = cyc;
        pulse(1'b1, 1'b0, 1'b0);
        wait_to(s + 4000);  expect_now("at999", 16'h0999, 1'b1, 1'b0, 1'b0);
        wait_to(s + 4001);  expect_now("at1000", 16'h1000, 1'b1, 1'b0, 1'b0);
        wait_to(s + 39997); expect_now("at9999", 16'h9999, 1'b1, 1'b0, 1'b0);
        wait_to(s + 40000); expect_now("at9999_last", 16'h9999, 1'b1, 1'b0, 1'b0);
        wait_to(s + 40001); expect_now("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        expect_now("ovf_pause", 16'h0000, 1'b0, 1'b0, 1'b1);
        wait_to(s + 40006); expect_now("ovf_sticky", 16'h0000, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        expect_now("ovf_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_to(s + 40012); expect_now("idle_after_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Triple pulse in PAUSE: clear wins and returns to IDLE.
        do_reset();
        s = cyc;
        pulse(1'b1, 1'b0, 1'b0);
        wait_to(s + 493);
        expect_now("at123", 16'h0123, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        expect_now("paused123", 16'h0123, 1'b0, 1'b0, 1'b0);
        wait_to(s + 497);
        pulse(1'b1, 1'b1, 1'b1);
        expect_now("triple_pause", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Triple pulse in RUN: clear and lap dropped, start_stop pauses.
        t = cyc;
        pulse(1'b1, 1'b0, 1'b0);
        wait_to(t + 9);   expect_now("restart_2", 16'h0002, 1'b1, 1'b0, 1'b0);
        wait_to(t + 10);
        pulse(1'b1, 1'b1, 1'b1);
        expect_now("triple_run", 16'h0002, 1'b0, 1'b0, 1'b0);
        wait_to(t + 20);  expect_now("triple_run_held", 16'h0002, 1'b0, 1'b0, 1'b0);

        // Reset during LAP_HOLD with concurrent pulses; later lap in IDLE is ignored.
        do_reset();
        s = cyc;
        pulse(1'b1, 1'b0, 1'b0);
        wait_to(s + 61);
        expect_now("at15", 16'h0015, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        expect_now("lap15", 16'h0015, 1'b1, 1'b1, 1'b0);
        wait_to(s + 64);
        reset_n = 1'b0; lap = 1'b1; start_stop = 1'b1;
        step();
        reset_n = 1'b1; lap = 1'b0; start_stop = 1'b0;
        check_now("rst_in_lap_direct", 16'h0000, 1'b0, 1'b0, 1'b0);
        expect_now("rst_in_lap", 16'h0000, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        expect_now("lap_in_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        wait_to(s + 70); expect_now("idle_hold", 16'h0000, 1'b0, 1'b0, 1'b0);

        step();
        step();
        if (q.size() != 0) begin
            bad += q.size();
            $display("FAIL expired: %0d expectation(s) never compared, first %s at cyc=%0d",
                     q.size(), q[0].tag, q[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad == 0) $display("PASS");
        else          $display("FAIL");
        $finish;
    end

endmodule
